// File: rtl/rv_mem_pkg.sv
// Shared types and helpers for the rvcore memory responder and its bench.
package rv_mem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } mem_port_t;

  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // Legal byte-enable / low-address combinations for one 32-bit access
  function automatic logic be_aligned(input logic [BE_W-1:0] be, input logic [1:0] addr_lo);
    logic ok;
    case (be)
      4'b1111:                            ok = (addr_lo == 2'b00);
      4'b0011, 4'b1100:                   ok = ~addr_lo[0];
      4'b0001, 4'b0010, 4'b0100, 4'b1000: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rv_mem_array.sv
// Single-ported byte-writable word RAM with asynchronous read.
module rv_mem_array
  import rv_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  localparam int unsigned IDX_W    = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  assign rdata_c = mem[idx];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/rv_mem_responder.sv
// Arbitrates rvcore fetch and data ports onto one RAM with programmable wait states.
module rv_mem_responder
  import rv_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_data,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [BE_W-1:0]   d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mem_port_t         last_q, last_d;
  mem_port_t         port_q, port_d;
  mem_req_t          req_q, req_d;
  logic              i_valid_q, i_valid_d;
  logic              i_err_q, i_err_d;
  logic [DATA_W-1:0] i_data_q, i_data_d;
  logic              d_valid_q, d_valid_d;
  logic              d_err_q, d_err_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  mem_port_t         gnt_c;
  mem_req_t          new_req_c;
  mem_port_t         acc_port_c;
  mem_req_t          acc_req_c;
  logic              acc_c;
  logic              err_c;
  logic              mem_we_c;
  logic [DATA_W-1:0] rdata_c;

  // Round-robin on ties; fetches are treated as full-word reads
  always_comb begin
    if (i_req && d_req) gnt_c = (last_q == PORT_I) ? PORT_D : PORT_I;
    else if (d_req)     gnt_c = PORT_D;
    else                gnt_c = PORT_I;
    new_req_c = '0;
    if (gnt_c == PORT_D) begin
      new_req_c.we    = d_we;
      new_req_c.be    = d_be;
      new_req_c.addr  = d_addr;
      new_req_c.wdata = d_wdata;
    end else begin
      new_req_c.be    = 4'b1111;
      new_req_c.addr  = i_addr;
    end
  end

  // With zero wait states the access happens on the grant edge from live inputs
  assign acc_port_c = (state_q == IDLE) ? gnt_c : port_q;
  assign acc_req_c  = (state_q == IDLE) ? new_req_c : req_q;
  assign err_c      = ({2'b00, acc_req_c.addr[ADDR_W-1:2]} >= ADDR_W'(MEM_WORDS)) ||
                      !be_aligned(acc_req_c.be, acc_req_c.addr[1:0]);
  assign mem_we_c   = acc_c && acc_req_c.we && !err_c && resetn;

  rv_mem_array #(
    .MEM_WORDS(MEM_WORDS)
  ) u_array (
    .clk     (clk),
    .we      (mem_we_c),
    .be      (acc_req_c.be),
    .idx     (acc_req_c.addr[IDX_W+1:2]),
    .wdata   (acc_req_c.wdata),
    .rdata_c (rdata_c)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    port_d    = port_q;
    req_d     = req_q;
    acc_c     = 1'b0;
    i_valid_d = 1'b0;
    i_err_d   = 1'b0;
    i_data_d  = '0;
    d_valid_d = 1'b0;
    d_err_d   = 1'b0;
    d_rdata_d = '0;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          port_d = gnt_c;
          last_d = gnt_c;
          req_d  = new_req_c;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
            acc_c   = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_STATES);
          end
        end
      end
      WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = RESP;
          cnt_d   = '0;
          acc_c   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Response registers load on the edge entering RESP
    if (acc_c) begin
      if (acc_port_c == PORT_D) begin
        d_valid_d = 1'b1;
        d_err_d   = err_c;
        d_rdata_d = (err_c || acc_req_c.we) ? '0 : rdata_c;
      end else begin
        i_valid_d = 1'b1;
        i_err_d   = err_c;
        i_data_d  = err_c ? '0 : rdata_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= PORT_I;
      port_q    <= PORT_I;
      req_q     <= '0;
      i_valid_q <= 1'b0;
      i_err_q   <= 1'b0;
      i_data_q  <= '0;
      d_valid_q <= 1'b0;
      d_err_q   <= 1'b0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      port_q    <= port_d;
      req_q     <= req_d;
      i_valid_q <= i_valid_d;
      i_err_q   <= i_err_d;
      i_data_q  <= i_data_d;
      d_valid_q <= d_valid_d;
      d_err_q   <= d_err_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign i_valid = i_valid_q;
  assign i_err   = i_err_q;
  assign i_data  = i_data_q;
  assign d_valid = d_valid_q;
  assign d_err   = d_err_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_rv_mem_responder.sv
// Scoreboard bench for rv_mem_responder: directed cases, random traffic, latency builds.
module tb_rv_mem_responder;
  import rv_mem_pkg::*;

  localparam int unsigned WS    = 1;
  localparam int unsigned WORDS = 1024;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          at;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_valid, i_err;
  logic [31:0] i_data;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_valid, d_err;
  logic [31:0] d_rdata;

  logic        x0_req = 1'b0, x3_req = 1'b0;
  logic        x0_valid, x0_err, x3_valid, x3_err;
  logic [31:0] x0_data, x3_data, x0_rdata, x3_rdata;
  logic        x0_dvalid, x0_derr, x3_dvalid, x3_derr;

  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        i_exp[$];
  exp_t        d_exp[$];
  logic [31:0] ref_mem [WORDS];
  logic [3:0]  be_tab [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rv_mem_responder #(.MEM_WORDS(WORDS), .WAIT_STATES(WS)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_data(i_data), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err)
  );

  rv_mem_responder #(.MEM_WORDS(WORDS), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .resetn(resetn),
    .i_req(x0_req), .i_addr(32'h0), .i_valid(x0_valid), .i_data(x0_data), .i_err(x0_err),
    .d_req(1'b0), .d_we(1'b0), .d_be(4'h0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_valid(x0_dvalid), .d_rdata(x0_rdata), .d_err(x0_derr)
  );

  rv_mem_responder #(.MEM_WORDS(WORDS), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .resetn(resetn),
    .i_req(x3_req), .i_addr(32'h0), .i_valid(x3_valid), .i_data(x3_data), .i_err(x3_err),
    .d_req(1'b0), .d_we(1'b0), .d_be(4'h0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_valid(x3_dvalid), .d_rdata(x3_rdata), .d_err(x3_derr)
  );

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference memory: word-addressed array updated byte-wise on legal writes
  function automatic void model_access(input logic we, input logic [3:0] be, input logic [31:0] addr,
                                       input logic [31:0] wdata, output logic [31:0] data, output logic err);
    int unsigned w;
    w    = addr >> 2;
    err  = (w >= WORDS) || !be_aligned(be, addr[1:0]);
    data = '0;
    if (!err && we) begin
      for (int b = 0; b < 4; b++) if (be[b]) ref_mem[w][8*b +: 8] = wdata[8*b +: 8];
    end else if (!err) begin
      data = ref_mem[w];
    end
  endfunction

  task automatic do_d(input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wdata, input int lag);
    exp_t e;
    logic done;
    done = 1'b0;
    @(posedge clk); #1;
    model_access(we, be, addr, wdata, e.data, e.err);
    e.at = cyc + 1 + int'(WS) + lag;
    d_exp.push_back(e);
    d_we = we; d_be = be; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    @(posedge clk); #1;
    if (lag == 0) begin
      d_we = 1'($urandom); d_be = 4'($urandom); d_addr = $urandom; d_wdata = $urandom;
    end
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (d_valid) begin done = 1'b1; break; end
    end
    d_req = 1'b0;
    cmp("d_handshake_done", 32'(done), 32'h1);
  endtask

  task automatic do_i(input logic [31:0] addr, input int lag);
    exp_t e;
    logic done;
    done = 1'b0;
    @(posedge clk); #1;
    model_access(1'b0, 4'hF, addr, 32'h0, e.data, e.err);
    e.at = cyc + 1 + int'(WS) + lag;
    i_exp.push_back(e);
    i_addr = addr; i_req = 1'b1;
    @(posedge clk); #1;
    if (lag == 0) i_addr = $urandom;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (i_valid) begin done = 1'b1; break; end
    end
    i_req = 1'b0;
    cmp("i_handshake_done", 32'(done), 32'h1);
  endtask

  task automatic check_reset_outputs();
    cmp("rst_i_valid", 32'(i_valid), 32'h0);
    cmp("rst_d_valid", 32'(d_valid), 32'h0);
    cmp("rst_errs", {30'h0, i_err, d_err}, 32'h0);
    cmp("rst_i_data", i_data, 32'h0);
    cmp("rst_d_rdata", d_rdata, 32'h0);
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (d_valid) begin
      if (d_exp.size() == 0) cmp("d_unexpected_valid", 32'h1, 32'h0);
      else begin
        exp_t e;
        e = d_exp.pop_front();
        cmp("d_rdata", d_rdata, e.data);
        cmp("d_err", 32'(d_err), 32'(e.err));
        cmp("d_valid_cycle", 32'(cyc), 32'(e.at));
      end
    end
    if (i_valid) begin
      if (i_exp.size() == 0) cmp("i_unexpected_valid", 32'h1, 32'h0);
      else begin
        exp_t e;
        e = i_exp.pop_front();
        cmp("i_data", i_data, e.data);
        cmp("i_err", 32'(i_err), 32'(e.err));
        cmp("i_valid_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  initial begin
    int t0, s0, s3;
    logic [31:0] v0, v3;
    be_tab = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h6};
    for (int i = 0; i < int'(WORDS); i++) begin
      ref_mem[i] = $urandom;
      dut.u_array.mem[i] <= ref_mem[i];
    end
    ref_mem[4] = 32'hDEADBEEF;
    dut.u_array.mem[4]   <= 32'hDEADBEEF;
    u_ws0.u_array.mem[0] <= 32'h0BADF00D;
    u_ws3.u_array.mem[0] <= 32'h13572468;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    resetn = 1'b1;

    // Basic fetch, byte write then read-back
    do_i(32'h10, 0);
    do_d(1'b1, 4'b0100, 32'h12, 32'h00AB0000, 0);
    do_d(1'b0, 4'b1111, 32'h10, 32'h0, 0);

    // Ties: first after reset goes to data, then alternate against last grant
    @(posedge clk); #1; resetn = 1'b0;
    @(negedge clk); check_reset_outputs();
    @(posedge clk); #1; resetn = 1'b1;
    fork
      do_d(1'b0, 4'hF, 32'h20, 32'h0, 0);
      do_i(32'h24, 2 + int'(WS));
    join
    do_d(1'b0, 4'hF, 32'h08, 32'h0, 0);
    fork
      do_i(32'h28, 0);
      do_d(1'b0, 4'hF, 32'h2C, 32'h0, 2 + int'(WS));
    join

    // Error responses leave memory untouched
    do_d(1'b1, 4'hF, 32'h11, 32'h12345678, 0);
    do_i(32'h1000, 0);
    do_i(32'h12, 0);
    do_d(1'b1, 4'h0, 32'h14, 32'hFFFFFFFF, 0);
    do_d(1'b1, 4'h6, 32'h14, 32'hFFFFFFFF, 0);
    do_d(1'b1, 4'h3, 32'h15, 32'hFFFFFFFF, 0);
    do_d(1'b1, 4'h3, 32'h16, 32'h0000C0DE, 0);
    do_d(1'b0, 4'hF, 32'h10, 32'h0, 0);
    do_d(1'b0, 4'hF, 32'h14, 32'h0, 0);

    // Reset during WAIT aborts a write
    @(posedge clk); #1;
    d_we = 1'b1; d_be = 4'hF; d_addr = 32'h40; d_wdata = 32'hCAFEF00D; d_req = 1'b1;
    @(posedge clk); #1; resetn = 1'b0;
    @(posedge clk); #1; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk); check_reset_outputs();
    @(posedge clk); #1; resetn = 1'b1;
    do_d(1'b0, 4'hF, 32'h40, 32'h0, 0);

    // Random sequential traffic over a small hot region plus out-of-range
    for (int n = 0; n < 80; n++) begin
      int unsigned w;
      logic [1:0]  lo;
      logic [31:0] a;
      w  = ($urandom_range(0, 9) == 0) ? $urandom_range(1024, 4095) : $urandom_range(0, 15);
      lo = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      a  = (32'(w) << 2) | 32'(lo);
      if ($urandom_range(0, 2) == 0) do_i(a, 0);
      else do_d(1'($urandom), ($urandom_range(0, 7) == 0) ? 4'($urandom) : be_tab[$urandom_range(0, 7)],
                a, $urandom, 0);
    end

    // Latency of the zero- and three-wait-state builds
    @(posedge clk); #1;
    t0 = cyc; s0 = -1; s3 = -1; v0 = '0; v3 = '0;
    x0_req = 1'b1; x3_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (x0_valid && s0 < 0) begin s0 = cyc; v0 = x0_data; x0_req = 1'b0; end
      if (x3_valid && s3 < 0) begin s3 = cyc; v3 = x3_data; x3_req = 1'b0; end
    end
    cmp("ws0_latency", 32'(s0), 32'(t0 + 1));
    cmp("ws3_latency", 32'(s3), 32'(t0 + 4));
    cmp("ws0_data", v0, 32'h0BADF00D);
    cmp("ws3_data", v3, 32'h13572468);

    for (int k = 0; k < 20 && (i_exp.size() + d_exp.size()) != 0; k++) @(negedge clk);
    cmp("scoreboard_drained", 32'(i_exp.size() + d_exp.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
